pow8_stream_sink: RTL and testbench

Synthesizable receiving end of the pow8 valid/ready result stream. The block accepts 64-bit results on a slave handshake port and applies pseudo-random backpressure. It checks each accepted beat against an internally generated expected value idx^8, and reports beat and error counts plus a done pulse. It sits after a pow8 datapath on the FPGA for on-board self-test, replacing the simulation-only output model.

---
 rtl/pow8_stream_sink_pkg.sv | 21 ++
 rtl/pow8_stream_sink_if.sv | 20 ++
 rtl/pow8_stream_sink_lfsr.sv | 36 +++
 rtl/pow8_stream_sink.sv | 142 ++++++++++++++
 tb/tb_pow8_stream_sink.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pow8_stream_sink_pkg.sv
// Shared definitions for the pow8 result-stream sink: FSM state codes,
// the squaring step count and the 16-bit LFSR tap set.
package pow8_hs_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CALC_STEPS = 3;

    // Feedback taps q[15], q[13], q[12], q[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/pow8_stream_sink_if.sv
// Valid/ready result stream carrying pow8 results from datapath to sink.
interface pow8_stream_sink_if #(
    parameter int DATA_W = 64
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/pow8_stream_sink_lfsr.sv
// 16-bit left-shifting Fibonacci LFSR used to throttle s_ready.
// A zero seed would lock the register up, so it is replaced by 1.
module hs_lfsr16
    import pow8_hs_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] q_reg;
    logic [15:0] q_next;

    assign q_next[0] = lfsr_fb(q_reg);

    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_shift
            assign q_next[gi] = q_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= SEED_EFF;
        end else if (en) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pow8_stream_sink.sv
// On-board pow8 result checker: regenerates idx^8 by three squarings, accepts
// one beat per index and counts mismatches. STREAM_SINK_RAND_READY_EN adds LFSR backpressure.
module pow8_stream_sink
    import pow8_hs_pkg::*;
#(
    parameter int          DATA_W    = 64,
    parameter int          CNT_W     = 32,
    parameter int          NUM_BEATS = 101,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    pow8_stream_sink_if.slave  s,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_beat_cnt,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [CNT_W-1:0]   o_first_err_idx
);
    state_t            state_reg;
    logic [1:0]        step_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic [CNT_W-1:0]  first_err_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [DATA_W-1:0] mul_in;
    logic [DATA_W-1:0] prod;
    logic              ready_gate;
    logic              ready_int;
    logic              hs;
    logic              last_beat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef STREAM_SINK_RAND_READY_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    hs_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == S_RECV),
        .q   (lfsr_q)
    );

    assign ready_gate  = lfsr_q[0];
    assign unused_lfsr = ^lfsr_q[15:1];
`else
    logic unused_seed;

    assign ready_gate  = 1'b1;
    assign unused_seed = ^LFSR_SEED;
`endif

    // Step 0 squares the index, later steps square the accumulator.
    assign mul_in    = (step_reg == 2'd0) ? DATA_W'(idx_reg) : acc_reg;
    assign prod      = mul_in * mul_in;
    assign ready_int = (state_reg == S_RECV) && ready_gate;
    assign hs        = s.s_valid && ready_int;
    assign last_beat = (idx_reg == CNT_W'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            step_reg      <= 2'd0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            beat_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            first_err_reg <= '1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_run) begin
                        state_reg     <= S_CALC;
                        step_reg      <= 2'd0;
                        idx_reg       <= '0;
                        beat_cnt_reg  <= '0;
                        err_cnt_reg   <= '0;
                        first_err_reg <= '1;
                        busy_reg      <= 1'b1;
                    end
                end
                S_CALC: begin
                    acc_reg <= prod;
                    if (step_reg == 2'(CALC_STEPS - 1)) begin
                        step_reg  <= 2'd0;
                        state_reg <= S_RECV;
                    end else begin
                        step_reg <= step_reg + 2'd1;
                    end
                end
                S_RECV: begin
                    if (hs) begin
                        beat_cnt_reg <= sat_inc(beat_cnt_reg);
                        if (s.s_data != acc_reg) begin
                            err_cnt_reg <= sat_inc(err_cnt_reg);
                            if (&first_err_reg) begin
                                first_err_reg <= idx_reg;
                            end
                        end
                        if (last_beat) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign s.s_ready       = ready_int;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;
    assign o_beat_cnt      = beat_cnt_reg;
    assign o_err_cnt       = err_cnt_reg;
    assign o_first_err_idx = first_err_reg;

endmodule

// File: tb/tb_pow8_stream_sink.sv
// Directed bench for pow8_stream_sink: a 101-beat instance with a cycle-level
// reference for s_ready/o_busy/o_done, and a 300-beat instance for truncation.
module tb_pow8_stream_sink;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_a = 1'b0;
    logic run_b = 1'b0;

    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] beat_a, err_a, first_a, beat_b, err_b, first_b;

    int checks = 0;
    int errors = 0;
    int done_cnt_a = 0;
    bit mon_en = 1'b0;

    pow8_stream_sink_if #(.DATA_W(64)) bus_a ();
    pow8_stream_sink_if #(.DATA_W(64)) bus_b ();

    pow8_stream_sink #(
        .DATA_W(64), .CNT_W(32), .NUM_BEATS(101), .LFSR_SEED(16'hACE1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .i_run(run_a), .s(bus_a),
        .o_busy(busy_a), .o_done(done_a), .o_beat_cnt(beat_a),
        .o_err_cnt(err_a), .o_first_err_idx(first_a)
    );

    pow8_stream_sink #(
        .DATA_W(64), .CNT_W(32), .NUM_BEATS(300), .LFSR_SEED(16'hACE1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .i_run(run_b), .s(bus_b),
        .o_busy(busy_b), .o_done(done_b), .o_beat_cnt(beat_b),
        .o_err_cnt(err_b), .o_first_err_idx(first_b)
    );

    always #5 clk = ~clk;

    // Cycle-level reference of the sink's control behaviour for instance A.
    typedef enum int {M_IDLE, M_CALC, M_RECV, M_DONE} mstate_t;
    mstate_t     m_state = M_IDLE;
    int          m_step = 0;
    int          m_idx = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          cyc = 0;
    int          last_hs = 0;
    int          hs_gap = 0;
    logic        m_ready;

`ifdef STREAM_SINK_RAND_READY_EN
    assign m_ready = (m_state == M_RECV) && m_lfsr[0];
`else
    assign m_ready = (m_state == M_RECV);
`endif

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.s_valid && bus_a.s_ready) begin
            hs_gap  <= cyc - last_hs;
            last_hs <= cyc;
        end
        if (rst) begin
            m_state <= M_IDLE;
            m_step  <= 0;
            m_idx   <= 0;
            m_lfsr  <= 16'hACE1;
        end else begin
            case (m_state)
                M_IDLE: if (run_a) begin
                    m_state <= M_CALC;
                    m_step  <= 0;
                    m_idx   <= 0;
                end
                M_CALC: if (m_step == 2) m_state <= M_RECV;
                        else m_step <= m_step + 1;
                M_RECV: begin
                    m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                    if (bus_a.s_valid && m_ready) begin
                        m_step <= 0;
                        if (m_idx == 100) m_state <= M_DONE;
                        else begin
                            m_idx   <= m_idx + 1;
                            m_state <= M_CALC;
                        end
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    function automatic logic [63:0] pow8(input int unsigned i);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < 8; k++) p = p * 64'(i);
        return p;
    endfunction

    // Caller is at a falling edge; returns at the falling edge after the handshake.
    task automatic send_a(input logic [63:0] data, input int gap);
        int t;
        bus_a.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = data;
        t = 0;
        while (!bus_a.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL send_a_timeout: waited %0d cycles, required < 200", t);
        end else begin
            @(negedge clk);
        end
        bus_a.s_valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] data);
        int t;
        bus_b.s_valid = 1'b1;
        bus_b.s_data  = data;
        t = 0;
        while (!bus_b.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL send_b_timeout: waited %0d cycles, required < 200", t);
        end else begin
            @(negedge clk);
        end
        bus_b.s_valid = 1'b0;
    endtask

    task automatic start_a();
        run_a = 1'b1;
        @(negedge clk);
        run_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus_a.s_ready, busy_a, done_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/done=%b required 000", {bus_a.s_ready, busy_a, done_a});
        end
        checks++;
        if (beat_a !== 32'd0 || err_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: beat=%0d err=%0d required 0 0", beat_a, err_a);
        end
        checks++;
        if (first_a !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL reset_first: got %h required ffffffff", first_a);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_clean_run();
        int dc;
        logic [63:0] d;
        dc = done_cnt_a;
        start_a();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL clean_busy: got %b required 1", busy_a);
        end
`ifndef STREAM_SINK_RAND_READY_EN
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus_a.s_ready !== (k == 3)) begin
                errors++;
                $display("FAIL clean_first_ready cycle %0d: got %b required %b", k, bus_a.s_ready, (k == 3));
            end
            if (k < 3) @(negedge clk);
        end
`endif
        for (int i = 0; i < 101; i++) begin
            d = (i == 3) ? 64'd6561 : (i == 100) ? 64'd10000000000000000 : pow8(i);
            send_a(d, 0);
`ifndef STREAM_SINK_RAND_READY_EN
            if (i > 0) begin
                checks++;
                if (hs_gap !== 4) begin
                    errors++;
                    $display("FAIL clean_hs_gap beat %0d: got %0d required 4", i, hs_gap);
                end
            end
`endif
        end
        checks++;
        if (done_a !== 1'b1 || beat_a !== 32'd101 || err_a !== 32'd0 || first_a !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL clean_result: done=%b beat=%0d err=%0d first=%h required 1 101 0 ffffffff",
                     done_a, beat_a, err_a, first_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || done_cnt_a !== dc + 1) begin
            errors++;
            $display("FAIL clean_end: busy=%b done=%b pulses=%0d required 0 0 %0d", busy_a, done_a, done_cnt_a - dc, 1);
        end
        $display("clean_run: beats=%0d errs=%0d", beat_a, err_a);
    endtask

    task automatic test_inject_error();
        logic [63:0] d;
        start_a();
        for (int i = 0; i < 101; i++) begin
            d = (i == 7) ? 64'd5764802 : (i == 9) ? pow8(9) + 64'd1 : pow8(i);
            send_a(d, 0);
            if (i == 8) begin
                checks++;
                if (err_a !== 32'd1 || first_a !== 32'd7) begin
                    errors++;
                    $display("FAIL inject_one: err=%0d first=%0d required 1 7", err_a, first_a);
                end
            end
        end
        checks++;
        if (err_a !== 32'd2 || first_a !== 32'd7 || beat_a !== 32'd101) begin
            errors++;
            $display("FAIL inject_two: err=%0d first=%0d beat=%0d required 2 7 101", err_a, first_a, beat_a);
        end
        @(negedge clk);
        $display("inject_error: errs=%0d first=%0d", err_a, first_a);
    endtask

    task automatic test_random_gaps();
        start_a();
        for (int i = 0; i < 101; i++) send_a(pow8(i), int'($urandom_range(0, 3)));
        checks++;
        if (beat_a !== 32'd101 || err_a !== 32'd0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL gaps_result: beat=%0d err=%0d done=%b required 101 0 1", beat_a, err_a, done_a);
        end
        @(negedge clk);
        $display("random_gaps: beats=%0d errs=%0d", beat_a, err_a);
    endtask

    task automatic test_run_ignored();
        start_a();
        for (int i = 0; i < 101; i++) begin
            if (i == 10) begin
                run_a = 1'b1;
                @(negedge clk);
                run_a = 1'b0;
            end
            if (i == 20) begin
                repeat (3) @(negedge clk);
                run_a = 1'b1;
                @(negedge clk);
                run_a = 1'b0;
            end
            send_a(pow8(i), 0);
        end
        checks++;
        if (beat_a !== 32'd101 || err_a !== 32'd0 || first_a !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL run_ignored: beat=%0d err=%0d first=%h required 101 0 ffffffff", beat_a, err_a, first_a);
        end
        @(negedge clk);
        $display("run_ignored: beats=%0d errs=%0d", beat_a, err_a);
    endtask

    task automatic test_rst_mid_run();
        int dc;
        start_a();
        for (int i = 0; i < 50; i++) send_a(pow8(i), 0);
        dc = done_cnt_a;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus_a.s_ready, busy_a, done_a} !== 3'b000 || beat_a !== 32'd0 || err_a !== 32'd0
            || first_a !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL rst_mid: ready/busy/done=%b beat=%0d err=%0d first=%h required 000 0 0 ffffffff",
                     {bus_a.s_ready, busy_a, done_a}, beat_a, err_a, first_a);
        end
        @(negedge clk);
        checks++;
        if (done_cnt_a !== dc) begin
            errors++;
            $display("FAIL rst_no_done: pulses=%0d required 0", done_cnt_a - dc);
        end
        start_a();
        for (int i = 0; i < 101; i++) send_a(pow8(i), 0);
        checks++;
        if (beat_a !== 32'd101 || err_a !== 32'd0) begin
            errors++;
            $display("FAIL rst_restart: beat=%0d err=%0d required 101 0", beat_a, err_a);
        end
        @(negedge clk);
        $display("rst_mid_run: restart beats=%0d errs=%0d", beat_a, err_a);
    endtask

    task automatic test_truncation();
        logic [63:0] d;
        run_b = 1'b1;
        @(negedge clk);
        run_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            d = (i == 256) ? 64'd0 : (i == 255) ? 64'd17878103347812890625 : pow8(i);
            send_b(d);
            if (i == 256) begin
                checks++;
                if (beat_b !== 32'd257 || err_b !== 32'd0) begin
                    errors++;
                    $display("FAIL trunc_256: beat=%0d err=%0d required 257 0", beat_b, err_b);
                end
            end
        end
        checks++;
        if (done_b !== 1'b1 || beat_b !== 32'd300 || err_b !== 32'd0 || first_b !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL trunc_result: done=%b beat=%0d err=%0d first=%h required 1 300 0 ffffffff",
                     done_b, beat_b, err_b, first_b);
        end
        @(negedge clk);
        $display("truncation: beats=%0d errs=%0d", beat_b, err_b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.s_valid = 1'b0;
        bus_a.s_data  = '0;
        bus_b.s_valid = 1'b0;
        bus_b.s_data  = '0;
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    checks++;
                    if (bus_a.s_ready !== m_ready) begin
                        errors++;
                        $display("FAIL mon_ready cyc %0d: got %b required %b", cyc, bus_a.s_ready, m_ready);
                    end
                    checks++;
                    if (busy_a !== (m_state != M_IDLE) || done_a !== (m_state == M_DONE)) begin
                        errors++;
                        $display("FAIL mon_busy_done cyc %0d: busy=%b done=%b required %b %b", cyc,
                                 busy_a, done_a, (m_state != M_IDLE), (m_state == M_DONE));
                    end
                    if (done_a === 1'b1) done_cnt_a++;
                end
            end
        join_none
        test_reset();
        test_clean_run();
        test_inject_error();
        test_random_gaps();
        test_run_ignored();
        test_rst_mid_run();
        test_truncation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
